// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Step counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_absval.sv
// Conditional two's-complement negate; yields the unsigned magnitude of a signed value
// when i_neg is set, or the raw value otherwise.
module seq_mult_absval #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-and-add multiplier, one partial product per clock,
// with optional signed operation handled by magnitude multiply plus sign fixup.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic               in_ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] yout,
  output logic               done
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg;
  logic [CntW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_yout;
  logic               r_done;
  logic               r_busy;
  logic               r_in_ready;

  logic               w_sgn;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;

  assign w_sgn   = is_signed & (SIGNED_EN != 0);
  assign w_neg_a = w_sgn & ain[WIDTH-1];
  assign w_neg_b = w_sgn & bin[WIDTH-1];

  seq_mult_absval #(
    .WIDTH (WIDTH)
  ) u_abs_a (
    .i_val (ain),
    .i_neg (w_neg_a),
    .o_val (w_mag_a)
  );

  seq_mult_absval #(
    .WIDTH (WIDTH)
  ) u_abs_b (
    .i_val (bin),
    .i_neg (w_neg_b),
    .o_val (w_mag_b)
  );

  // Final {acc, multiplier} holds the unsigned product; negate when signs differ.
  seq_mult_absval #(
    .WIDTH (2 * WIDTH)
  ) u_fixup (
    .i_val ({r_acc, r_b}),
    .i_neg (r_neg),
    .o_val (w_prod)
  );

  // Carry lands in w_sum[WIDTH] and is shifted back into the accumulator MSB.
  assign w_sum  = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_yout     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a        <= w_mag_a;
            r_b        <= w_mag_b;
            r_neg      <= w_neg_a ^ w_neg_b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= StCalc;
          end
        end
        StCalc: begin
          r_acc <= w_sum[WIDTH:1];
          r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= StFin;
          end
        end
        StFin: begin
          r_yout     <= w_prod;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= StIdle;
        end
        default: begin
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign yout     = r_yout;
  assign done     = r_done;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed self-checking bench for seq_mult_param: 16-bit signed-capable, 16-bit
// unsigned-only and 8-bit instances driven from one shared stimulus bus.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic        sgn_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  int          sel = 0;
  int          cyc = 0;

  logic [31:0] y16, yu;
  logic [15:0] y8;
  logic        done16, doneu, done8;
  logic        busy16, busyu, busy8;
  logic        rdy16, rdyu, rdy8;

  logic [63:0] obs_y;
  logic        obs_done, obs_busy, obs_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_param #(.WIDTH(16), .SIGNED_EN(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .is_signed(sgn_in),
    .ain(a_in), .bin(b_in), .in_ready(rdy16), .busy(busy16), .yout(y16), .done(done16)
  );

  seq_mult_param #(.WIDTH(16), .SIGNED_EN(0)) u_dut16u (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .is_signed(sgn_in),
    .ain(a_in), .bin(b_in), .in_ready(rdyu), .busy(busyu), .yout(yu), .done(doneu)
  );

  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .is_signed(sgn_in),
    .ain(a_in[7:0]), .bin(b_in[7:0]), .in_ready(rdy8), .busy(busy8), .yout(y8), .done(done8)
  );

  always_comb begin
    obs_y    = {32'd0, y16};
    obs_done = done16;
    obs_busy = busy16;
    obs_rdy  = rdy16;
    case (sel)
      1: begin
        obs_y = {32'd0, yu}; obs_done = doneu; obs_busy = busyu; obs_rdy = rdyu;
      end
      2: begin
        obs_y = {48'd0, y8}; obs_done = done8; obs_busy = busy8; obs_rdy = rdy8;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Launch one operation on instance s; optionally re-pulse start poke_at cycles in.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic sg, input int poke_at, output logic [63:0] y,
                        output int edges, output int nbusy, output int nrdy);
    sel = s;
    @(negedge clk);
    a_in = a; b_in = b; sgn_in = sg;
    start_v = '0;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = '0;
    edges = 0; nbusy = 0; nrdy = 0;
    while (!obs_done && edges < 40) begin
      if (obs_busy) nbusy++;
      if (obs_rdy) nrdy++;
      if (edges == poke_at) begin
        a_in = 16'h00FF; b_in = 16'h00FF; start_v[s] = 1'b1;
      end else begin
        start_v = '0;
      end
      @(negedge clk);
      edges++;
    end
    start_v = '0;
    y = obs_y;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (obs_done) cnt++;
    end
  endtask

  logic [63:0] y;
  int edges, nbusy, nrdy, nd, t, c1;

  initial begin
    sel = 0;
    #12;
    check("rst_yout", {32'd0, y16}, 64'd0);
    check("rst_done", {63'd0, done16}, 64'd0);
    check("rst_ready", {63'd0, rdy16}, 64'd1);
    check("rst_busy", {63'd0, busy16}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'hFFFF, 16'hFFFF, 1'b0, -1, y, edges, nbusy, nrdy);
    check("u_ffff_y", y, 64'hFFFE0001);
    check("u_ffff_lat", edges, 17);
    check("u_ffff_busy", nbusy, 17);
    check("u_ffff_rdy", nrdy, 0);
    @(negedge clk);
    check("u_ffff_done1", {63'd0, done16}, 64'd0);

    run_op(0, 16'hFFFD, 16'h0005, 1'b1, -1, y, edges, nbusy, nrdy);
    check("s_m3x5_y", y, 64'hFFFFFFF1);
    check("s_m3x5_lat", edges, 17);
    run_op(0, 16'h8000, 16'h8000, 1'b1, -1, y, edges, nbusy, nrdy);
    check("s_minsq_y", y, 64'h40000000);
    run_op(0, 16'h8000, 16'h0001, 1'b1, -1, y, edges, nbusy, nrdy);
    check("s_minx1_y", y, 64'hFFFF8000);

    run_op(1, 16'hFFFD, 16'h0005, 1'b1, -1, y, edges, nbusy, nrdy);
    check("noseg_y", y, 64'h0004FFF1);
    check("noseg_lat", edges, 17);

    run_op(0, 16'h0003, 16'h0004, 1'b0, 5, y, edges, nbusy, nrdy);
    check("poke_y", y, 64'h0000000C);
    check("poke_lat", edges, 17);
    count_done(25, nd);
    check("poke_nodone", nd, 0);
    check("poke_hold", {32'd0, y16}, 64'h0000000C);

    // Reset partway through CALC.
    sel = 0;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; sgn_in = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y", {32'd0, y16}, 64'd0);
    check("mid_rst_done", {63'd0, done16}, 64'd0);
    check("mid_rst_rdy", {63'd0, rdy16}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(25, nd);
    check("mid_rst_nodone", nd, 0);

    run_op(0, 16'd7, 16'd6, 1'b0, -1, y, edges, nbusy, nrdy);
    check("post_rst_y", y, 64'h0000002A);

    // start held high across two operations.
    sel = 0;
    @(negedge clk);
    a_in = 16'd2; b_in = 16'd3; sgn_in = 1'b0; start_v[0] = 1'b1;
    t = 0;
    while (!obs_done && t < 40) begin @(negedge clk); t++; end
    check("b2b_y1", obs_y, 64'h6);
    c1 = cyc;
    a_in = 16'd4; b_in = 16'd5;
    @(negedge clk);
    start_v = '0;
    t = 0;
    while (!obs_done && t < 40) begin @(negedge clk); t++; end
    check("b2b_y2", obs_y, 64'h14);
    check("b2b_gap", cyc - c1, 18);

    run_op(2, 16'd200, 16'd3, 1'b0, -1, y, edges, nbusy, nrdy);
    check("w8_600_y", y, 64'h0258);
    check("w8_600_lat", edges, 9);
    run_op(2, 16'h0080, 16'h00FF, 1'b1, -1, y, edges, nbusy, nrdy);
    check("w8_s_y", y, 64'h0080);
    check("w8_s_lat", edges, 9);
    run_op(2, 16'h0000, 16'h00FF, 1'b1, -1, y, edges, nbusy, nrdy);
    check("w8_zero_y", y, 64'h0000);
    check("w8_zero_lat", edges, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
